// File: rtl/bin_a_bcd.sv
// Iterative binary-to-BCD converter (shift-add-3) with a start/done handshake
// and a leading-zero blanking mask for the 7-segment display stage.
module bin_a_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iniciar,
  input  logic [WIDTH-1:0]      binario,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blanco,
  output logic                  ocupado,
  output logic                  terminado
);

  localparam int REG_W = 4*DIGITS + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state;
  logic [REG_W-1:0]     sreg;
  logic [REG_W-1:0]     sreg_adj;
  logic [CNT_W-1:0]     cnt;

  // Every BCD nibble >= 5 gets +3; nibbles are independent, so no carries.
  function automatic logic [REG_W-1:0] add3(input logic [REG_W-1:0] r);
    logic [REG_W-1:0] o;
    o = r;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[WIDTH+4*i +: 4] >= 4'd5)
        o[WIDTH+4*i +: 4] = r[WIDTH+4*i +: 4] + 4'd3;
    end
    return o;
  endfunction

  // Digit i is blanked when it and all higher digits are zero; units never are.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [4*DIGITS-1:0] d);
    logic [DIGITS-1:0] m;
    logic              all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int i = DIGITS-1; i >= 1; i--) begin
      all_zero = all_zero & (d[4*i +: 4] == 4'd0);
      m[i]     = all_zero;
    end
    return m;
  endfunction

  assign sreg_adj = add3(sreg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      bcd       <= '0;
      blanco    <= '0;
      ocupado   <= 1'b0;
      terminado <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iniciar) begin
            sreg      <= {{(4*DIGITS){1'b0}}, binario};
            cnt       <= '0;
            ocupado   <= 1'b1;
            terminado <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          sreg <= {sreg_adj[REG_W-2:0], 1'b0};
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1))
            state <= DONE;
        end
        DONE: begin
          bcd       <= sreg[REG_W-1:WIDTH];
          blanco    <= blank_mask(sreg[REG_W-1:WIDTH]);
          terminado <= 1'b1;
          ocupado   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_a_bcd.sv
// Directed bench for bin_a_bcd: decimal reference model, scoreboard queue,
// latency/handshake checks and a boundary-plus-random value sweep.
module tb_bin_a_bcd;

  logic        clk;
  logic        rst_n;
  logic        iniciar;
  logic [15:0] binario;
  logic [19:0] bcd;
  logic [4:0]  blanco;
  logic        ocupado;
  logic        terminado;

  int errors = 0;
  int checks = 0;

  logic [24:0] sb_q[$];
  logic [19:0] prev_bcd = '0;
  logic [4:0]  prev_blk = '0;

  bin_a_bcd #(.WIDTH(16), .DIGITS(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iniciar   (iniciar),
    .binario   (binario),
    .bcd       (bcd),
    .blanco    (blanco),
    .ocupado   (ocupado),
    .terminado (terminado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int          p;
    r = '0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_blank(input int v);
    logic [4:0] m;
    int         p;
    m = '0;
    p = 10;
    for (int i = 1; i < 5; i++) begin
      m[i] = (v < p);
      p = p * 10;
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a start in the current (inactive-edge) slot and push the expectation.
  task automatic start_now(input int v);
    binario = 16'(v);
    iniciar = 1'b1;
    @(posedge clk);
    sb_q.push_back({ref_bcd(v), ref_blank(v)});
    #1;
    iniciar = 1'b0;
    binario = 16'($urandom);
  endtask

  task automatic do_start(input int v);
    @(negedge clk);
    start_now(v);
  endtask

  // Called right after the accepting edge; optionally injects an extra start.
  task automatic wait_done(input string tag, input int inj_at, input int inj_val);
    int          k;
    int          busy;
    logic [24:0] e;
    k    = 0;
    busy = 0;
    @(negedge clk);
    chk({tag, "_term_drop"}, 32'(terminado), 32'd0);
    chk({tag, "_bcd_held"}, 32'(bcd), 32'(prev_bcd));
    while (!terminado && k < 40) begin
      if (ocupado) busy++;
      if (k == inj_at) begin
        binario = 16'(inj_val);
        iniciar = 1'b1;
      end else begin
        iniciar = 1'b0;
      end
      k++;
      @(negedge clk);
    end
    iniciar = 1'b0;
    chk({tag, "_latency"}, 32'(k), 32'd17);
    chk({tag, "_busy_cycles"}, 32'(busy), 32'd17);
    chk({tag, "_ocupado_done"}, 32'(ocupado), 32'd0);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_bcd"}, 32'(bcd), 32'(e[24:5]));
      chk({tag, "_blanco"}, 32'(blanco), 32'(e[4:0]));
      prev_bcd = e[24:5];
      prev_blk = e[4:0];
    end
  endtask

  initial begin
    int vals[$];
    rst_n   = 1'b0;
    iniciar = 1'b0;
    binario = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_blanco", 32'(blanco), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_terminado", 32'(terminado), 32'd0);
    rst_n = 1'b1;

    do_start(0);
    wait_done("zero", -1, 0);
    chk("zero_bcd_const", 32'(bcd), 32'h00000);
    chk("zero_blanco_const", 32'(blanco), 32'b11110);

    do_start(65535);
    wait_done("max", -1, 0);
    chk("max_bcd_const", 32'(bcd), 32'h65535);

    do_start(144);
    wait_done("v144", -1, 0);
    chk("v144_blanco_const", 32'(blanco), 32'b11000);
    chk("b2b_term_before", 32'(terminado), 32'd1);
    start_now(1000);
    wait_done("v1000_b2b", -1, 0);
    chk("v1000_bcd_const", 32'(bcd), 32'h01000);
    chk("v1000_blanco_const", 32'(blanco), 32'b10000);

    do_start(255);
    wait_done("ignored_start", 5, 9);
    chk("ignored_bcd_const", 32'(bcd), 32'h00255);
    repeat (3) @(negedge clk);
    chk("ignored_no_restart", 32'(ocupado), 32'd0);

    do_start(12345);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_bcd", 32'(bcd), 32'd0);
    chk("midrst_blanco", 32'(blanco), 32'd0);
    chk("midrst_ocupado", 32'(ocupado), 32'd0);
    chk("midrst_terminado", 32'(terminado), 32'd0);
    rst_n = 1'b1;
    void'(sb_q.pop_front());
    prev_bcd = '0;
    prev_blk = '0;
    do_start(12345);
    wait_done("after_rst", -1, 0);
    chk("after_rst_bcd_const", 32'(bcd), 32'h12345);

    vals = '{1, 9, 10, 99, 100, 999, 9999, 10000, 10001, 59999, 65534};
    for (int i = 0; i < 250; i++) vals.push_back(int'($urandom_range(0, 65535)));
    foreach (vals[i]) begin
      do_start(vals[i]);
      wait_done("sweep", -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
